// File: rtl/inter_tx.sv
// inter_tx: transmit engine for the inter-board link.
// Buffers {type, number} game messages in a small FIFO and sends each one as
// two 6-bit beats over a 4-phase Request/Ack handshake.
//   clk, rst                    clock, synchronous active-high reset
//   transmit, ctrl_msg_type,
//   ctrl_number                 one-cycle enqueue strobe and message fields
//   Ack_in                      asynchronous acknowledge from the peer
//   Request_out, inter_data_out request and beat data to the peer
//   inter_ready                 FIFO not full
//   busy                        FIFO non-empty or handshake in progress
//   msg_done, overflow          one-cycle completion / dropped-message pulses
module inter_tx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transmit,
    input  logic [2:0] ctrl_msg_type,
    input  logic [4:0] ctrl_number,
    input  logic       Ack_in,
    output logic       Request_out,
    output logic [5:0] inter_data_out,
    output logic       inter_ready,
    output logic       busy,
    output logic       msg_done,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, REQ, RELEASE} state_t;

    state_t                 state_q, state_d;
    logic                   beat_q, beat_d;
    logic                   req_q, req_d;
    logic [5:0]             data_q, data_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;
    logic                   rdy_q, rdy_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [CW-1:0]          count_q, count_d;
    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [7:0]             mem_d [FIFO_DEPTH];
    logic [7:0]             head;
    logic                   ack_s, full, wr, pop;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], Ack_in};
        ack_s  = sync_q[SYNC_STAGES-1];
        // full is taken from the pre-pop count, so a write coinciding with a pop is still refused
        full   = count_q == CW'(FIFO_DEPTH);
        wr     = transmit && !full;
        head   = mem_q[rd_ptr_q];
        rd_nxt = rd_ptr_q + AW'(1);
        pop     = 1'b0;
        state_d = state_q;
        beat_d  = beat_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (count_q != '0) begin
                data_d  = {3'b100, head[7:5]};
                beat_d  = 1'b0;
                state_d = SETUP;
            end
            SETUP: begin
                req_d   = 1'b1;
                state_d = REQ;
            end
            REQ: if (ack_s) begin
                req_d   = 1'b0;
                state_d = RELEASE;
            end
            RELEASE: if (!ack_s) begin
                if (!beat_q) begin
                    data_d  = {1'b0, head[4:0]};
                    beat_d  = 1'b1;
                    state_d = SETUP;
                end else begin
                    pop    = 1'b1;
                    done_d = 1'b1;
                    // chain straight into the next stored message without an IDLE cycle
                    if (count_q > CW'(1)) begin
                        data_d  = {3'b100, mem_q[rd_nxt][7:5]};
                        beat_d  = 1'b0;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        mem_d = mem_q;
        if (wr) mem_d[wr_ptr_q] = {ctrl_msg_type, ctrl_number};
        wr_ptr_d = wr_ptr_q + AW'(wr);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(wr) - CW'(pop);
        ovf_d    = transmit && full;
        rdy_d    = count_d != CW'(FIFO_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= 1'b0;
            req_q    <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rdy_q    <= 1'b1;
            sync_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            req_q    <= req_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            rdy_q    <= rdy_d;
            sync_q   <= sync_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign Request_out    = req_q;
    assign inter_data_out = data_q;
    assign inter_ready    = rdy_q;
    assign msg_done       = done_q;
    assign overflow       = ovf_q;
    assign busy           = (state_q != IDLE) || (count_q != '0);
endmodule

// File: doc/inter_tx.md
Name: inter_tx

Overview:
- Transmit-side engine for the inter-board link; sits directly downstream of the game controller.
- Accepts game messages (3-bit type, 5-bit number) on a one-cycle strobe and buffers them in a small FIFO.
- Sends each message to the peer board as two 6-bit beats, using a 4-phase Request/Ack handshake on Request_out / Ack_in / inter_data_out.
- Reports buffer space back to the controller via inter_ready.

Parameters:
- FIFO_DEPTH, 4, message buffer entries (power of 2, ≥2).
- SYNC_STAGES, 2, flip-flop stages synchronising the asynchronous Ack_in (≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- transmit  in  1  one-cycle strobe: enqueue {ctrl_msg_type, ctrl_number}.
- ctrl_msg_type  in  3  message type; sampled when transmit=1.
- ctrl_number  in  5  message payload number (0..24); sampled when transmit=1.
- Ack_in  in  1  acknowledge from the peer board; asynchronous.
- Request_out  out  1  request to the peer board.
- inter_data_out  out  6  beat data to the peer board.
- inter_ready  out  1  FIFO not full; a transmit strobe will be accepted.
- busy  out  1  FIFO non-empty or handshake in progress.
- msg_done  out  1  one-cycle pulse when a message's second beat completes.
- overflow  out  1  one-cycle pulse when transmit arrives while the FIFO is full.

Behaviour:
Reset (synchronous, rst=1 at a clk edge):
- Request_out=0, inter_data_out=0, busy=0, msg_done=0, overflow=0, inter_ready=1.
- FIFO emptied, state=IDLE, synchroniser flops cleared.
- Reset mid-handshake drops everything immediately; Request_out falls on the same edge.

Beat encoding:
- Beat0 = {1'b1, 2'b00, msg_type}.
- Beat1 = {1'b0, number}.
- Bit 5 marks the first beat of a message.

Synchronisation:
- ack_s = Ack_in after SYNC_STAGES flops.
- Only ack_s is used by the FSM.

FIFO:
- Write on transmit && !full.
- Pop only when the FSM finishes beat1.
- transmit while full: message dropped, overflow=1 for one cycle, FIFO unchanged.
- Simultaneous write and pop while full: the write is still rejected, because full is evaluated before the pop.
- inter_ready = !full, registered from FIFO count.

FSM (state, beat flag):
- IDLE:
  - If FIFO non-empty: load beat0 onto inter_data_out, go to SETUP (beat=0).
- SETUP:
  - Data is held stable for one full cycle.
  - Next cycle: Request_out<=1, go to REQ.
- REQ:
  - Hold Request_out=1 and the data until ack_s=1.
  - Then Request_out<=0, go to RELEASE.
- RELEASE:
  - Wait for ack_s=0.
  - If beat=0: load beat1, go to SETUP (beat=1).
  - If beat=1: pop FIFO, msg_done=1 for one cycle.
    - If the FIFO still holds another entry (count after pop >0), load its beat0 and go to SETUP (beat=0).
    - Otherwise go to IDLE.
- Data is never changed while Request_out=1 or while ack_s=1.

Latency:
- transmit at edge T into an empty, idle block:
  - FIFO write at T.
  - inter_data_out=beat0 after T+1.
  - Request_out=1 after T+2.
- Ack_in rise → Request_out fall: SYNC_STAGES+1 edges.
- Ack_in fall → next beat's data: SYNC_STAGES+1 edges; its Request one edge later.

Other rules:
- busy = (state!=IDLE) || FIFO non-empty.
- Ack_in already high when entering REQ (peer stuck): the FSM completes the phase normally; there is no timeout.
- Glitches on Ack_in shorter than the synchroniser window may be missed; the peer must hold Ack until Request falls.
- FIFO pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.

Test Plan:
1. Reset then idle 10 cycles → Request_out=0, inter_data_out=0, inter_ready=1, busy=0.
2. transmit type=3'd2 number=5'd17, peer model acks 3 cycles after Request and releases 3 cycles after Request falls → beat0=6'b100010 then beat1=6'b010001; Request_out rises 2 cycles after transmit; msg_done pulses once after the final Ack release; busy returns to 0.
3. Back-to-back transmits (1,5),(2,9),(4,24) on consecutive cycles → six beats in order 100001, 000101, 100010, 001001, 100100, 011000; exactly three msg_done pulses.
4. Five transmits with Ack_in held 0 (FIFO_DEPTH=4) → inter_ready falls after the 4th write; the 5th gives overflow=1 for one cycle; after the peer resumes, exactly four messages are delivered.
5. Assert rst while Request_out=1 mid beat1 → Request_out=0, FIFO empty, busy=0 on the next edge; a following transmit (3,7) sends cleanly as 100011, 000111.
6. Randomised peer Ack delays (1–20 cycles) over 200 messages → scoreboard shows every beat matches, with no data change while Request_out or synced Ack is high.
